// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes A/B/index, filters A/B for FILT stable samples,
// then decodes gray-code steps into a wrapping position count with step/wrap pulses and sticky err.
module quad_decoder #(
  parameter int N         = 8,
  parameter int MAX_COUNT = 2**N - 1,
  parameter int FILT      = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         quad_a,
  input  logic         quad_b,
  input  logic         index,
  input  logic         index_en,
  input  logic         err_clr,
  output logic [N-1:0] count,
  output logic         dir,
  output logic         step,
  output logic         wrap,
  output logic         err
);

  localparam logic [N-1:0] MAXC   = N'(MAX_COUNT);
  localparam logic [4:0]   FILT_W = 5'(FILT);

  logic [1:0] ab_s1, ab_s2;
  logic       idx_s1, idx_s2, idx_prev;

  logic [1:0] ab_f, ab_f_n, ab_prev, cand, cand_n;
  logic [3:0] run_cnt, run_n;
  logic [4:0] run_inc;

  logic [N-1:0] count_n;
  logic         dir_n, step_n, wrap_n, err_n;

  logic [1:0] delta;
  logic       up, dn, ill, idx_rise;

  // Gray code {A,B} to quadrant position: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // A candidate change must hold unchanged for FILT samples; any other value restarts the run.
  always_comb begin
    ab_f_n  = ab_f;
    cand_n  = cand;
    run_n   = run_cnt;
    run_inc = 5'd0;
    if (ab_s2 == ab_f) begin
      run_n = 4'd0;
    end else begin
      if (run_cnt != 4'd0 && ab_s2 != cand) run_inc = 5'd1;
      else                                   run_inc = {1'b0, run_cnt} + 5'd1;
      if (run_inc >= FILT_W) begin
        ab_f_n = ab_s2;
        run_n  = 4'd0;
      end else begin
        cand_n = ab_s2;
        run_n  = run_inc[3:0];
      end
    end
  end

  assign delta    = gray_pos(ab_f) - gray_pos(ab_prev);
  assign up       = (delta == 2'd1);
  assign dn       = (delta == 2'd3);
  assign ill      = (delta == 2'd2);
  assign idx_rise = idx_s2 & ~idx_prev;

  always_comb begin
    count_n = count;
    dir_n   = dir;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
    err_n   = err;
    if (ill)          err_n = 1'b1;
    else if (err_clr) err_n = 1'b0;
    // Index clear takes priority over a step decoded in the same cycle.
    if (idx_rise && index_en) begin
      count_n = '0;
    end else if (up) begin
      step_n = 1'b1;
      dir_n  = 1'b1;
      if (count == MAXC) begin
        count_n = '0;
        wrap_n  = 1'b1;
      end else begin
        count_n = count + 1'b1;
      end
    end else if (dn) begin
      step_n = 1'b1;
      dir_n  = 1'b0;
      if (count == '0) begin
        count_n = MAXC;
        wrap_n  = 1'b1;
      end else begin
        count_n = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ab_s1    <= 2'b00;
      ab_s2    <= 2'b00;
      idx_s1   <= 1'b0;
      idx_s2   <= 1'b0;
      idx_prev <= 1'b0;
      ab_f     <= 2'b00;
      ab_prev  <= 2'b00;
      cand     <= 2'b00;
      run_cnt  <= 4'd0;
      count    <= '0;
      dir      <= 1'b1;
      step     <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ab_s1    <= {quad_a, quad_b};
      ab_s2    <= ab_s1;
      idx_s1   <= index;
      idx_s2   <= idx_s1;
      idx_prev <= idx_s2;
      ab_f     <= ab_f_n;
      ab_prev  <= ab_f;
      cand     <= cand_n;
      run_cnt  <= run_n;
      count    <= count_n;
      dir      <= dir_n;
      step     <= step_n;
      wrap     <= wrap_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (N=8, MAX_COUNT=255, FILT=2): vector table plus
// hand-written sequences for filter latency, err clear, index priority and reset.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset, quad_a, quad_b, index, index_en, err_clr;
  logic [7:0] count;
  logic       dir, step, wrap, err;

  int passed = 0;
  int total  = 0;
  int steps_seen = 0;
  int wraps_seen = 0;
  int p = 0;
  logic [1:0] gray_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  typedef struct {
    logic a;
    logic b;
    int   hold;
    int   exp_count;
    logic exp_dir;
    logic exp_err;
    int   exp_steps;
    int   exp_wraps;
  } vec_t;

  vec_t tbl [12];

  quad_decoder #(.N(8), .MAX_COUNT(255), .FILT(2)) dut (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
    .index(index), .index_en(index_en), .err_clr(err_clr),
    .count(count), .dir(dir), .step(step), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      steps_seen += int'(step);
      wraps_seen += int'(wrap);
    end
  endtask

  task automatic clr_cnt();
    steps_seen = 0;
    wraps_seen = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic drive_pos(input int np);
    p = np;
    {quad_a, quad_b} = gray_of[p];
  endtask

  task automatic up_step();
    drive_pos((p + 1) % 4);
    run(6);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 10,   1, 1'b1, 1'b0, 1, 0};
    tbl[1]  = '{1'b1, 1'b1, 10,   2, 1'b1, 1'b0, 1, 0};
    tbl[2]  = '{1'b1, 1'b0, 10,   3, 1'b1, 1'b0, 1, 0};
    tbl[3]  = '{1'b0, 1'b0, 10,   4, 1'b1, 1'b0, 1, 0};
    tbl[4]  = '{1'b1, 1'b0, 10,   3, 1'b0, 1'b0, 1, 0};
    tbl[5]  = '{1'b1, 1'b1, 10,   2, 1'b0, 1'b0, 1, 0};
    tbl[6]  = '{1'b0, 1'b1, 10,   1, 1'b0, 1'b0, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, 10,   0, 1'b0, 1'b0, 1, 0};
    tbl[8]  = '{1'b1, 1'b0, 10, 255, 1'b0, 1'b0, 1, 1};
    tbl[9]  = '{1'b0, 1'b0, 10,   0, 1'b1, 1'b0, 1, 1};
    tbl[10] = '{1'b1, 1'b1, 10,   0, 1'b1, 1'b1, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 10,   0, 1'b1, 1'b1, 0, 0};

    reset = 1'b1; quad_a = 1'b0; quad_b = 1'b0;
    index = 1'b0; index_en = 1'b0; err_clr = 1'b0;
    run(3);
    check("rst_count", int'(count), 0);
    check("rst_dir",   int'(dir),   1);
    check("rst_step",  int'(step),  0);
    check("rst_wrap",  int'(wrap),  0);
    check("rst_err",   int'(err),   0);
    reset = 1'b0;
    run(2);
    check("rel_count", int'(count), 0);

    for (int i = 0; i < 12; i++) begin
      clr_cnt();
      quad_a = tbl[i].a;
      quad_b = tbl[i].b;
      run(tbl[i].hold);
      check($sformatf("vec%0d_count", i), int'(count), tbl[i].exp_count);
      check($sformatf("vec%0d_dir", i),   int'(dir),   int'(tbl[i].exp_dir));
      check($sformatf("vec%0d_err", i),   int'(err),   int'(tbl[i].exp_err));
      check($sformatf("vec%0d_steps", i), steps_seen,  tbl[i].exp_steps);
      check($sformatf("vec%0d_wraps", i), wraps_seen,  tbl[i].exp_wraps);
    end
    p = 0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr0", int'(err), 0);

    // Glitch rejection and exact filter latency on an up step 01 -> 11.
    drive_pos(1);
    run(8);
    check("pre_glitch_count", int'(count), 1);
    clr_cnt();
    quad_a = 1'b1;
    tick();
    quad_a = 1'b0;
    run(8);
    check("glitch_count", int'(count), 1);
    check("glitch_steps", steps_seen, 0);
    drive_pos(2);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) begin
        check($sformatf("lat_hold%0d", k), int'(count), 1);
        check($sformatf("lat_nostep%0d", k), int'(step), 0);
      end else begin
        check("lat_count", int'(count), 2);
        check("lat_step",  int'(step),  1);
      end
    end
    run(4);
    check("lat_single_pulse", int'(step), 0);

    // Illegal 11 -> 00, then err_clr, then err_clr against a new illegal change.
    clr_cnt();
    drive_pos(0);
    run(8);
    check("ill_err",   int'(err),   1);
    check("ill_count", int'(count), 2);
    check("ill_steps", steps_seen,  0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr", int'(err), 0);
    drive_pos(2);
    run(4);
    check("ill2_pre", int'(err), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ill_wins_clr", int'(err), 1);
    check("ill2_count", int'(count), 2);
    run(4);

    for (int i = 0; i < 35; i++) up_step();
    check("count37", int'(count), 37);

    // Index rising edge lands on the same edge as an up step.
    drive_pos((p + 1) % 4);
    tick();
    tick();
    index_en = 1'b1;
    index = 1'b1;
    tick(); tick(); tick();
    check("idx_count", int'(count), 0);
    check("idx_step",  int'(step),  0);
    check("idx_wrap",  int'(wrap),  0);
    tick();
    check("idx_after", int'(count), 0);
    index = 1'b0;
    run(6);
    up_step();
    check("post_idx_up", int'(count), 1);
    index_en = 1'b0;
    index = 1'b1;
    run(8);
    check("idx_disabled", int'(count), 1);
    index = 1'b0;
    run(4);

    for (int i = 0; i < 100; i++) up_step();
    check("count101", int'(count), 101);
    drive_pos((p + 3) % 4);
    run(6);
    check("count100", int'(count), 100);
    check("dir_down", int'(dir),   0);

    // Reset during a pending filter run; held 01 is then filtered against 00 as an up step.
    clr_cnt();
    drive_pos(1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst2_count", int'(count), 0);
    check("rst2_dir",   int'(dir),   1);
    check("rst2_err",   int'(err),   0);
    check("rst2_step",  int'(step),  0);
    check("rst2_wrap",  int'(wrap),  0);
    reset = 1'b0;
    clr_cnt();
    run(10);
    check("rst2_refilter_count", int'(count), 1);
    check("rst2_refilter_dir",   int'(dir),   1);
    check("rst2_refilter_steps", steps_seen,  1);
    check("rst2_refilter_err",   int'(err),   0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter N, default 8, width of position count.
REQ-002 Parameter MAX_COUNT, default 2**N-1, highest count value; legal range 1..2**N-1.
REQ-003 Parameter FILT, default 2, number of consecutive stable synchronized samples required to accept an A/B change; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 quad_a  input  1  encoder channel A, asynchronous to clk.
REQ-007 quad_b  input  1  encoder channel B, asynchronous to clk.
REQ-008 index  input  1  encoder index mark, asynchronous to clk.
REQ-009 index_en  input  1  synchronous; 1 enables count clear on index rising edge.
REQ-010 err_clr  input  1  synchronous; 1 clears sticky err.
REQ-011 count  output  N  position count, registered.
REQ-012 dir  output  1  direction of last valid step: 1 = up, 0 = down; registered.
REQ-013 step  output  1  one-cycle pulse per valid count change; registered.
REQ-014 wrap  output  1  one-cycle pulse when count wraps in either direction; registered.
REQ-015 err  output  1  sticky illegal-transition flag; registered.

Function
REQ-016 quad_a, quad_b, index each pass through a two-flop synchronizer before any use.
REQ-017 Filter: filtered pair ab_f takes the synchronized {A,B} value once it differs from ab_f and holds for FILT consecutive clk samples; any intermediate change restarts the run.
REQ-018 Decode on each ab_f update, {A,B} order 00->01->11->10->00 = up step; reverse order = down step.
REQ-019 ab_f update in which both bits change = illegal: no count change, no step, dir unchanged, err set.
REQ-020 Latency: with A/B held stable, count, dir, step update on the (FILT+3)th rising edge after the first edge that samples the new A/B level.
REQ-021 Up step at count==MAX_COUNT: count<=0, wrap=1; otherwise count<=count+1.
REQ-022 Down step at count==0: count<=MAX_COUNT, wrap=1; otherwise count<=count-1.
REQ-023 step=1 for exactly one cycle per valid step, including wrap steps; step and wrap are 0 otherwise.
REQ-024 Index: synchronized index rising edge with index_en=1 sets count<=0 on the next edge; step=0, wrap=0, dir unchanged.
REQ-025 Index clear and valid step in the same cycle: index wins, count=0, step=0.
REQ-026 Index rising edge with index_en=0: no effect.
REQ-027 err_clr=1 clears err on the next edge; a new illegal transition in the same cycle wins, err stays 1.
REQ-028 Count arithmetic is modulo MAX_COUNT+1; count never exceeds MAX_COUNT.

Reset
REQ-029 reset=1 on a rising edge sets count=0, dir=1, step=0, wrap=0, err=0, synchronizers=0, ab_f=00, filter run counter=0, index edge history=0.
REQ-030 reset overrides all other inputs in the same cycle, including index and valid steps.
REQ-031 reset mid-filter-run discards the pending A/B change; after release, the held A/B level is filtered anew against ab_f=00.
REQ-032 First cycle after reset release: outputs hold reset values until a new step, index, or error is decoded.

Verification
REQ-033 Reset, then 4 up steps (00->01->11->10->00, each held 10 cycles) -> count=4, dir=1, 4 single-cycle step pulses, err=0.
REQ-034 count=0, one down step (00->10) -> count=MAX_COUNT (255), dir=0, step=1 and wrap=1 for one cycle; then one up step -> count=0, wrap=1.
REQ-035 FILT=2, A pulse of 1 cycle, then A held 10 cycles -> no change from the glitch; count increments on edge 5 after the first sample of the held level.
REQ-036 ab_f=00, A and B rise together -> count unchanged, step=0, err=1; err_clr=1 for one cycle -> err=0; err_clr coincident with another illegal change -> err=1.
REQ-037 count=37, index_en=1, index rising edge coincident with up step -> count=0, step=0; index_en=0 with index edge -> count unchanged.
REQ-038 reset=1 asserted at count=100 during a pending filter run -> next edge count=0, dir=1, err=0, no step pulse.
